// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store front-end:
//               access-mode encoding, FSM state encoding, I/O register
//               offsets, address-region tags, plus alignment and byte-lane
//               helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size/extension as presented by the core's memory stage.
    typedef enum logic [2:0] {
        MODE_BYTE  = 3'd0,
        MODE_HALF  = 3'd1,
        MODE_WORD  = 3'd2,
        MODE_BYTEU = 3'd4,
        MODE_HALFU = 3'd5
    } lsu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    typedef enum logic [2:0] {
        RGN_DMEM = 3'd0,
        RGN_LEDR = 3'd1,
        RGN_LEDG = 3'd2,
        RGN_HEX  = 3'd3,
        RGN_SW   = 3'd4,
        RGN_KEY  = 3'd5,
        RGN_NONE = 3'd6
    } lsu_region_e;

    // Register offsets inside the I/O page.
    localparam logic [31:0] c_IO_LEDR_OFF = 32'h0000_0000;
    localparam logic [31:0] c_IO_LEDG_OFF = 32'h0000_0010;
    localparam logic [31:0] c_IO_HEX_OFF  = 32'h0000_0020;
    localparam logic [31:0] c_IO_SW_OFF   = 32'h0000_0800;
    localparam logic [31:0] c_IO_KEY_OFF  = 32'h0000_0810;

    // Natural alignment check; reserved modes never pass.
    function automatic logic is_aligned(input logic [2:0] mode, input logic [1:0] lane);
        logic ok;
        case (mode)
            MODE_BYTE, MODE_BYTEU: ok = 1'b1;
            MODE_HALF, MODE_HALFU: ok = ~lane[0];
            MODE_WORD:             ok = (lane == 2'b00);
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [2:0] mode, input logic [1:0] lane);
        logic [3:0] m;
        case (mode)
            MODE_BYTE, MODE_BYTEU: m = 4'b0001 << lane;
            MODE_HALF, MODE_HALFU: m = 4'b0011 << lane;
            MODE_WORD:             m = 4'b1111;
            default:               m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ldext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ldext
// Description : Combinational load-data formatter. Shifts the addressed byte
//               lane down to bit 0 and sign- or zero-extends per mode.
// Ports       : i_word  - 32-bit word read from the target
//               i_lane  - byte lane of the access within i_word
//               i_mode  - access mode (byte/half/word, signed/unsigned)
//               o_data  - extended load data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ldext
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_mode,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_word >> {i_lane, 3'b000};

    always_comb begin
        o_data = 32'd0;
        case (i_mode)
            MODE_BYTE:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MODE_HALF:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MODE_WORD:  o_data = w_shifted;
            MODE_BYTEU: o_data = {24'd0, w_shifted[7:0]};
            MODE_HALFU: o_data = {16'd0, w_shifted[15:0]};
            default:    o_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store front-end between the core memory stage and the
//               byte-addressed data memory. Three-state handshake
//               (IDLE -> ACCESS -> RESP), region decode, alignment checking,
//               LED/HEX output registers and synchronised SW/KEY inputs.
// Ports       : clk_i/rst_i           - clock, synchronous active-high reset
//               req_*                 - request handshake from the core
//               rsp_*                 - one-cycle response pulse + data/error
//               dmem_*                - data-memory port (comb. read, clocked write)
//               sw_i/key_i            - raw asynchronous switch/button inputs
//               ledr_o/ledg_o/hex_o   - memory-mapped output registers
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
    parameter logic [31:0] DMEM_LAST = 32'h0000_3FFF,
    parameter logic [31:0] IO_BASE   = 32'h0000_7000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_mode_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        dmem_st_en_o,
    output logic [2:0]  dmem_mode_o,
    output logic [13:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic [17:0] sw_i,
    input  logic [3:0]  key_i,
    output logic [16:0] ledr_o,
    output logic [7:0]  ledg_o,
    output logic [31:0] hex_o
);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_ACCESS = ST_ACCESS;
    localparam logic [1:0] c_ST_RESP   = ST_RESP;

    localparam logic [31:0] c_LEDR_ADDR = IO_BASE + c_IO_LEDR_OFF;
    localparam logic [31:0] c_LEDG_ADDR = IO_BASE + c_IO_LEDG_OFF;
    localparam logic [31:0] c_HEX_ADDR  = IO_BASE + c_IO_HEX_OFF;
    localparam logic [31:0] c_SW_ADDR   = IO_BASE + c_IO_SW_OFF;
    localparam logic [31:0] c_KEY_ADDR  = IO_BASE + c_IO_KEY_OFF;

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_we;
    logic [2:0]  r_mode;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [16:0] r_ledr;
    logic [7:0]  r_ledg;
    logic [31:0] r_hex;

    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;
    logic [3:0]  r_key_meta;
    logic [3:0]  r_key_sync;

    // ------------------------------------------------------------------
    // Decode of the captured request
    // ------------------------------------------------------------------
    logic [1:0]  w_lane;
    logic        w_aligned;
    logic        w_access;
    logic        w_err;
    lsu_region_e w_region;
    logic [31:0] w_io_rdata;
    logic [3:0]  w_be;
    logic [31:0] w_bitmask;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_io_merged;
    logic        w_io_wr;
    logic [31:0] w_ld_word;
    logic [1:0]  w_ld_lane;
    logic [31:0] w_ld_data;

    assign w_lane    = r_addr[1:0];
    assign w_aligned = is_aligned(r_mode, w_lane);
    assign w_access  = (r_state == c_ST_ACCESS);

    // I/O registers match on the word address so sub-word accesses hit
    // any lane of the register.
    always_comb begin
        w_region = RGN_NONE;
        if ((r_addr >= DMEM_BASE) && (r_addr <= DMEM_LAST)) begin
            w_region = RGN_DMEM;
        end else if (r_addr[31:2] == c_LEDR_ADDR[31:2]) begin
            w_region = RGN_LEDR;
        end else if (r_addr[31:2] == c_LEDG_ADDR[31:2]) begin
            w_region = RGN_LEDG;
        end else if (r_addr[31:2] == c_HEX_ADDR[31:2]) begin
            w_region = RGN_HEX;
        end else if (r_addr[31:2] == c_SW_ADDR[31:2]) begin
            w_region = RGN_SW;
        end else if (r_addr[31:2] == c_KEY_ADDR[31:2]) begin
            w_region = RGN_KEY;
        end
    end

    always_comb begin
        w_io_rdata = 32'd0;
        case (w_region)
            RGN_LEDR: w_io_rdata = {15'd0, r_ledr};
            RGN_LEDG: w_io_rdata = {24'd0, r_ledg};
            RGN_HEX:  w_io_rdata = r_hex;
            RGN_SW:   w_io_rdata = {14'd0, r_sw_sync};
            RGN_KEY:  w_io_rdata = {28'd0, r_key_sync};
            default:  w_io_rdata = 32'd0;
        endcase
    end

    assign w_err = ~w_aligned | (w_region == RGN_NONE);

    // Sub-word store merge: move LSB-aligned store data up to its lane and
    // replace only the enabled bytes of the current register value.
    assign w_be       = lane_mask(r_mode, w_lane);
    assign w_wdata_sh = r_wdata << {w_lane, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_bitmask[8*gi +: 8] = {8{w_be[gi]}};
        end
    endgenerate

    assign w_io_merged = (w_io_rdata & ~w_bitmask) | (w_wdata_sh & w_bitmask);
    assign w_io_wr     = w_access & r_we & w_aligned;

    // Data memory already returns the addressed lane at bit 0; I/O words
    // still need the lane shift.
    assign w_ld_word = (w_region == RGN_DMEM) ? dmem_rdata_i : w_io_rdata;
    assign w_ld_lane = (w_region == RGN_DMEM) ? 2'b00 : w_lane;

    lsu_ldext u_ldext (
        .i_word (w_ld_word),
        .i_lane (w_ld_lane),
        .i_mode (r_mode),
        .o_data (w_ld_data)
    );

    // ------------------------------------------------------------------
    // FSM and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_we    <= 1'b0;
            r_mode  <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_mode  <= req_mode_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: r_state <= c_ST_RESP;
                c_ST_RESP:   r_state <= c_ST_IDLE;
                default:     r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Response payload is latched at the end of ACCESS and presented in RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_access) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (!r_we && !w_err) ? w_ld_data : 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Memory-mapped output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ledr <= 17'd0;
            r_ledg <= 8'd0;
            r_hex  <= 32'd0;
        end else if (w_io_wr) begin
            case (w_region)
                RGN_LEDR: r_ledr <= w_io_merged[16:0];
                RGN_LEDG: r_ledg <= w_io_merged[7:0];
                RGN_HEX:  r_hex  <= w_io_merged;
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous board inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_meta  <= 18'd0;
            r_sw_sync  <= 18'd0;
            r_key_meta <= 4'd0;
            r_key_sync <= 4'd0;
        end else begin
            r_sw_meta  <= sw_i;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= key_i;
            r_key_sync <= r_key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o  = (r_state == c_ST_IDLE);
    assign rsp_valid_o  = (r_state == c_ST_RESP);
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_err_o    = r_rsp_err;

    // Gated by reset so a store aborted during ACCESS never reaches memory.
    assign dmem_st_en_o = w_access & r_we & w_aligned & (w_region == RGN_DMEM) & ~rst_i;
    assign dmem_mode_o  = {1'b0, r_mode[1:0]};
    assign dmem_addr_o  = r_addr[13:0];
    assign dmem_wdata_o = r_wdata;

    assign ledr_o = r_ledr;
    assign ledg_o = r_ledg;
    assign hex_o  = r_hex;

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store front-end between the single-cycle core's memory stage and the byte-addressed data memory (window 0x2000–0x3FFF, 14-bit address, 3-bit datamode, combinational read, clocked write).
- Accepts one request per handshake and decodes the address region.
- Rejects misaligned or unmapped accesses.
- Drives the data-memory port and owns the memory-mapped LED/HEX output registers and the synchronised switch/key inputs.
- Returns load data sign- or zero-extended after a fixed 2-cycle latency.

Parameters:
- DMEM_BASE, 32'h0000_2000, first byte of the data-memory window.
- DMEM_LAST, 32'h0000_3FFF, last byte of the data-memory window.
- IO_BASE, 32'h0000_7000, base of the I/O register page (4 KiB).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1=store, 0=load.
- req_mode_i  in  3  0 byte, 1 half, 2 word, 4 byte-unsigned, 5 half-unsigned.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, LSB-aligned.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data (0 for stores/errors).
- rsp_err_o  out  1  misaligned or unmapped; qualified by rsp_valid_o.
- dmem_st_en_o  out  1  data-memory write enable.
- dmem_mode_o  out  3  0 byte, 1 half, 2 word.
- dmem_addr_o  out  14  data-memory byte address.
- dmem_wdata_o  out  32  data-memory store data.
- dmem_rdata_i  in  32  data-memory combinational read data.
- sw_i  in  18  raw switches (asynchronous).
- key_i  in  4  raw push-buttons (asynchronous).
- ledr_o  out  17  red LED register.
- ledg_o  out  8  green LED register.
- hex_o  out  32  four 7-seg digit bytes, HEX0 in [7:0].

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, dmem_st_en_o=0.
  - ledr_o=0, ledg_o=0, hex_o=0.
  - Synchroniser flops cleared.
- IDLE:
  - req_ready_o=1.
  - On valid, capture we, mode, addr and wdata into request registers and go to ACCESS.
- ACCESS:
  - req_ready_o=0.
  - dmem_addr_o=addr[13:0]; dmem_mode_o=mode[1:0]; dmem_wdata_o=wdata.
  - dmem_st_en_o=1 only when store, in the dmem window, and aligned.
  - Load data (dmem_rdata_i or I/O read value) captured at the end of the cycle.
  - Go to RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, req_ready_o=0, then return to IDLE.
  - Accept-to-response latency is 2 cycles; maximum throughput is one request per 3 cycles.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - Mode 3, 6 or 7 is treated as misaligned.
  - Misaligned gives err=1, no write, rdata=0.
- Regions:
  - DMEM_BASE..DMEM_LAST: data memory.
  - IO_BASE+0x000: LEDR (R/W).
  - IO_BASE+0x010: LEDG (R/W).
  - IO_BASE+0x020: HEX (R/W).
  - IO_BASE+0x800: SW (RO).
  - IO_BASE+0x810: KEY (RO).
  - Anything else is unmapped: err=1, stores dropped, rdata=0.
  - Stores to SW/KEY: dropped, err=0.
- I/O store merge:
  - Byte and half stores update only the addressed byte lanes of the 32-bit register (lane = addr[1:0]).
  - Bits beyond a register's width are ignored on write and read as 0.
- I/O writes are committed in the ACCESS cycle and are visible on ledr_o/ledg_o/hex_o from the next cycle.
- Load extension:
  - Extract the byte or half at lane addr[1:0] of the word read.
  - For the dmem window, the lane is already at [7:0]/[15:0] of dmem_rdata_i.
  - Modes 0/1 sign-extend; modes 4/5 zero-extend; mode 2 passes through.
- sw_i and key_i pass through a 2-flop synchroniser; reads return the synchronised value.
- req_valid_i while not in IDLE is ignored; the request must be held until accepted.
- rst_i asserted in any state:
  - Return to IDLE next cycle.
  - Abort the in-flight request with no write and no rsp_valid_o.
  - Clear the I/O registers.

Decomposition:
- Package lsu_pkg holds:
  - mode enum: BYTE, HALF, WORD, BYTEU, HALFU.
  - FSM state enum.
  - I/O offset constants.
  - region enum: DMEM, LEDR, LEDG, HEX, SW, KEY, NONE.
- One sub-module, lsu_ldext: combinational lane select and sign/zero extension.

Test Plan:
- Store word 0xDEADBEEF @0x2004, then load word @0x2004 → dmem_st_en_o high for exactly one cycle, rsp_valid_o 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- Load byte and byte-unsigned @0x2007 with stored 0xDE → rdata 0xFFFFFFDE and 0x000000DE respectively.
- Store half @0x2003 → err=1, dmem_st_en_o never asserted, rdata=0.
- Store byte 0x5A @IO_BASE+0x021 with hex_o=0 → hex_o=0x00005A00 the cycle after ACCESS; load word @IO_BASE+0x020 returns 0x00005A00.
- sw_i=0x2AAAA, wait 2 cycles, load @IO_BASE+0x800 → rdata=0x0002AAAA; load @0x5000 → err=1, rdata=0.
- Assert rst_i during ACCESS of a store → no write, no rsp_valid_o, IDLE with req_ready_o=1 the next cycle.
